// File: rtl/counterdown16_1clk_posedge_sync_resetn.sv
// Loadable down counter/timer with valid/ready load and one-cycle done pulse.
// Define COUNTERDOWN16_AUTORELOAD_EN to reload the start value at terminal and keep running.
module counterdown16_1clk_posedge_sync_resetn #(
    parameter int WIDTH = 16
) (
    input  logic             clock0,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Declaration initializers make power-up match the reset state.
    state_t           state_q = IDLE;
    state_t           state_d;
    logic [WIDTH-1:0] count_q = '0;
    logic [WIDTH-1:0] count_d;
    logic             done_q  = 1'b0;
    logic             done_d;

`ifdef COUNTERDOWN16_AUTORELOAD_EN
    logic [WIDTH-1:0] reload_q = '0;
    logic [WIDTH-1:0] reload_d;
`endif

    always_ff @(posedge clock0) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            done_q   <= 1'b0;
`ifdef COUNTERDOWN16_AUTORELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            done_q   <= done_d;
`ifdef COUNTERDOWN16_AUTORELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        done_d   = 1'b0;
`ifdef COUNTERDOWN16_AUTORELOAD_EN
        reload_d = reload_q;
`endif
        case (state_q)
            IDLE: begin
                // A zero load just clears the count; it never starts a run.
                if (load_valid) begin
                    count_d = load_value;
                    if (load_value != '0) begin
                        state_d  = RUN;
`ifdef COUNTERDOWN16_AUTORELOAD_EN
                        reload_d = load_value;
`endif
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (enable) begin
                    // Terminal is caught at 1 so the count never wraps in RUN.
                    if (count_q == WIDTH'(1)) begin
                        done_d  = 1'b1;
`ifdef COUNTERDOWN16_AUTORELOAD_EN
                        count_d = reload_q;
`else
                        count_d = '0;
                        state_d = IDLE;
`endif
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign count      = count_q;
    assign done       = done_q;
    assign running    = (state_q == RUN);
    assign load_ready = (state_q == IDLE);

endmodule

// File: tb/tb_counterdown16_1clk_posedge_sync_resetn.sv
// Randomized bench with a behavioural timer model; directed sequences pin the model.
module tb_counterdown16_1clk_posedge_sync_resetn;

    logic        clock0 = 1'b0;
    logic        reset = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_value = '0;
    logic        enable = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] count;
    logic        running;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: a timer that is either armed or not.
    logic [15:0] m_count  = '0;
    logic [15:0] m_reload = '0;
    bit          m_armed  = 1'b0;
    bit          m_done   = 1'b0;

    counterdown16_1clk_posedge_sync_resetn #(.WIDTH(16)) dut (
        .clock0     (clock0),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .enable     (enable),
        .abort      (abort),
        .count      (count),
        .running    (running),
        .done       (done)
    );

    always #5 clock0 = ~clock0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        m_done = 1'b0;
        if (!reset) begin
            m_count  = '0;
            m_reload = '0;
            m_armed  = 1'b0;
        end else if (!m_armed) begin
            if (load_valid) begin
                m_count = load_value;
                if (load_value != 0) begin
                    m_armed  = 1'b1;
                    m_reload = load_value;
                end
            end
        end else if (abort) begin
            m_armed = 1'b0;
        end else if (enable) begin
            if (m_count == 16'd1) begin
                m_done = 1'b1;
`ifdef COUNTERDOWN16_AUTORELOAD_EN
                m_count = m_reload;
`else
                m_count = 16'd0;
                m_armed = 1'b0;
`endif
            end else begin
                m_count = m_count - 16'd1;
            end
        end
    endtask

    // One clock: inputs change after the falling edge, model advances with the rising edge.
    task automatic tick(input bit lv, input logic [15:0] val, input bit en, input bit ab, input bit rst_n);
        @(negedge clock0);
        #1;
        load_valid = lv;
        load_value = val;
        enable     = en;
        abort      = ab;
        reset      = rst_n;
        @(posedge clock0);
        model_step();
        #2;
    endtask

    always @(negedge clock0) begin
        chk("model.count", 32'(count), 32'(m_count));
        chk("model.done", 32'(done), 32'(m_done));
        chk("model.running", 32'(running), 32'(m_armed));
        chk("model.load_ready", 32'(load_ready), 32'(!m_armed));
    end

    initial begin
        // Reset with a load presented: it must be ignored.
        tick(1, 16'h1234, 0, 0, 0);
        tick(1, 16'h1234, 0, 0, 0);
        chk("rst.count", 32'(count), 32'h0);
        chk("rst.done", 32'(done), 32'h0);
        chk("rst.running", 32'(running), 32'h0);
        chk("rst.load_ready", 32'(load_ready), 32'h1);

`ifndef COUNTERDOWN16_AUTORELOAD_EN
        begin
            logic [15:0] seq [6] = '{16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0};
            tick(1, 16'd5, 1, 0, 1);
            chk("oneshot.count0", 32'(count), 32'(seq[0]));
            chk("oneshot.run0", 32'(running), 32'h1);
            for (int i = 1; i < 6; i++) begin
                tick(0, 16'd0, 1, 0, 1);
                chk("oneshot.count", 32'(count), 32'(seq[i]));
                chk("oneshot.done", 32'(done), 32'(i == 5));
            end
            chk("oneshot.running_end", 32'(running), 32'h0);
            chk("oneshot.ready_end", 32'(load_ready), 32'h1);
            tick(0, 16'd0, 1, 0, 1);
            chk("oneshot.done_once", 32'(done), 32'h0);
        end
`endif

        // Enable gating with an ignored load attempt, then abort.
        tick(1, 16'hFFFF, 0, 0, 1);
        chk("gate.load", 32'(count), 32'hFFFF);
        begin
            bit en = 1'b1;
            int guard = 0;
            logic [15:0] prev;
            while (count != 16'hFFFA && guard < 20) begin
                prev = count;
                tick(guard % 3 == 0, 16'h0007, en, 0, 1);
                chk("gate.ready_low", 32'(load_ready), 32'h0);
                chk("gate.step", 32'(count), en ? 32'(prev - 16'd1) : 32'(prev));
                en = ~en;
                guard++;
            end
            chk("gate.reached", 32'(guard < 20), 32'h1);
        end
        tick(0, 16'd0, 1, 1, 1);
        chk("abort.count", 32'(count), 32'hFFFA);
        chk("abort.running", 32'(running), 32'h0);
        chk("abort.done", 32'(done), 32'h0);

        // Zero load clears the count and stays idle.
        tick(1, 16'd0, 1, 0, 1);
        chk("zero.count", 32'(count), 32'h0);
        chk("zero.running", 32'(running), 32'h0);
        chk("zero.done", 32'(done), 32'h0);

`ifdef COUNTERDOWN16_AUTORELOAD_EN
        begin
            logic [15:0] aseq [10] = '{16'd3, 16'd2, 16'd1, 16'd3, 16'd2, 16'd1, 16'd3, 16'd2, 16'd1, 16'd3};
            tick(1, 16'd3, 1, 0, 1);
            chk("auto.count0", 32'(count), 32'(aseq[0]));
            chk("auto.done0", 32'(done), 32'h0);
            for (int i = 1; i < 10; i++) begin
                tick(0, 16'd0, 1, 0, 1);
                chk("auto.count", 32'(count), 32'(aseq[i]));
                chk("auto.done", 32'(done), 32'(aseq[i] == 16'd3));
                chk("auto.running", 32'(running), 32'h1);
            end
            tick(0, 16'd0, 1, 1, 1);
            chk("auto.abort", 32'(running), 32'h0);
        end
`endif

        // Reset in the middle of a run.
        tick(1, 16'd100, 1, 0, 1);
        for (int i = 0; i < 10; i++) tick(0, 16'd0, 1, 0, 1);
        chk("midrst.pre", 32'(count), 32'd90);
        tick(0, 16'd0, 1, 0, 0);
        chk("midrst.count", 32'(count), 32'h0);
        chk("midrst.running", 32'(running), 32'h0);
        chk("midrst.done", 32'(done), 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            tick($urandom_range(0, 3) == 0,
                 ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 8)),
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 49) != 0);
        end

        @(negedge clock0);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
